// File: rtl/servo_sweep_sequencer_pkg.sv
// Shared types and defaults for the lock servo sweep sequencer and its step prescaler.
// servo_ctrl uses the same end-stop and step-rate defaults.
package servo_pkg;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } servo_state_t;

    localparam int unsigned DEF_RES        = 8;
    localparam int unsigned DEF_STEP_TICKS = 2_499_999;
    localparam int unsigned DEF_DUTY_LOCK  = 95;
    localparam int unsigned DEF_DUTY_OPEN  = 255;
    localparam int unsigned DEF_HOLD_STEPS = 200;

    // End stops must be ordered and representable in the RES+1 bit duty word.
    function automatic bit params_legal(input int unsigned res,
                                        input int unsigned duty_lock,
                                        input int unsigned duty_open);
        longint unsigned duty_max;
        duty_max = (64'd1 << (res + 1)) - 64'd1;
        return (duty_lock < duty_open) && (longint'(duty_open) <= duty_max);
    endfunction

endpackage

// File: rtl/servo_sweep_sequencer_if.sv
// Request/status bundle between the lock FSM (master) and the sweep sequencer (slave).
// Requests are single-cycle pulses sampled on the next clock edge; there is no back-pressure.
interface servo_sweep_sequencer_if #(
    parameter int unsigned RES = servo_pkg::DEF_RES
);
    import servo_pkg::*;

    logic         unlock_req;
    logic         lock_req;
    logic [RES:0] duty;
    logic         busy;
    logic         is_open;
    logic         done;
    servo_state_t state_dbg;

    modport master (
        output unlock_req, lock_req,
        input  duty, busy, is_open, done, state_dbg
    );

    modport slave (
        input  unlock_req, lock_req,
        output duty, busy, is_open, done, state_dbg
    );

endinterface

// File: rtl/servo_sweep_sequencer_step_tick.sv
// Step-rate prescaler: counts 0..STEP_TICKS and flags the wrap cycle as a one-cycle tick.
// clear_i restarts the count so the first tick after a clear lands STEP_TICKS+1 cycles later.
module servo_step_tick
    import servo_pkg::*;
#(
    parameter int unsigned STEP_TICKS = DEF_STEP_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign tick_o = (cnt_q == STEP_TICKS);

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_sweep_sequencer.sv
// Lock servo sequencer: ramps PWM duty between the locked and open end stops one step per
// prescaler tick, holds the bolt open for a bounded time, and always favours locking.
module servo_sweep_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned RES        = DEF_RES,
    parameter int unsigned STEP_TICKS = DEF_STEP_TICKS,
    parameter int unsigned DUTY_LOCK  = DEF_DUTY_LOCK,
    parameter int unsigned DUTY_OPEN  = DEF_DUTY_OPEN,
    parameter int unsigned HOLD_STEPS = DEF_HOLD_STEPS
) (
    input logic                     clk,
    input logic                     reset,
    servo_sweep_sequencer_if.slave  bus
);

    localparam int unsigned     DW     = RES + 1;
    localparam logic [DW-1:0]   LOCK_V = DW'(DUTY_LOCK);
    localparam logic [DW-1:0]   OPEN_V = DW'(DUTY_OPEN);

    if (!params_legal(RES, DUTY_LOCK, DUTY_OPEN)) begin : g_bad_params
        $error("servo_sweep_sequencer: need DUTY_LOCK < DUTY_OPEN <= 2**(RES+1)-1");
    end

    servo_state_t  state_q, state_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] duty_up, duty_dn;
    logic [31:0]   hold_q, hold_d;
    logic          done_q, done_d;
    logic          busy_q, is_open_q;
    logic          step_clear;
    logic          step_tick;
    logic          unlock_only;

    servo_step_tick #(
        .STEP_TICKS (STEP_TICKS)
    ) u_step_tick (
        .clk     (clk),
        .reset   (reset),
        .clear_i (step_clear),
        .tick_o  (step_tick)
    );

    // Saturating single steps keep duty inside the end stops even on a reversal at a stop.
    assign duty_up = (duty_q < OPEN_V) ? duty_q + DW'(1) : duty_q;
    assign duty_dn = (duty_q > LOCK_V) ? duty_q - DW'(1) : duty_q;

    // lock_req beats unlock_req when both arrive together.
    assign unlock_only = bus.unlock_req && !bus.lock_req;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        done_d  = 1'b0;

        unique case (state_q)
            LOCKED: begin
                if (unlock_only) begin
                    state_d = OPENING;
                end
            end
            OPENING: begin
                if (bus.lock_req) begin
                    state_d = CLOSING;
                end else if (step_tick) begin
                    duty_d = duty_up;
                    if (duty_up == OPEN_V) begin
                        state_d = OPEN;
                        hold_d  = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (bus.lock_req) begin
                    state_d = CLOSING;
                end else if (bus.unlock_req) begin
                    hold_d = '0;
                end else if (step_tick) begin
                    hold_d = hold_q + 32'd1;
                    if ((HOLD_STEPS != 0) && (hold_q + 32'd1 == HOLD_STEPS)) begin
                        state_d = CLOSING;
                    end
                end
            end
            CLOSING: begin
                if (unlock_only) begin
                    state_d = OPENING;
                end else if (step_tick) begin
                    duty_d = duty_dn;
                    if (duty_dn == LOCK_V) begin
                        state_d = LOCKED;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOCKED;
                duty_d  = LOCK_V;
            end
        endcase
    end

    // Every entry into a timed state restarts the step period from zero.
    assign step_clear = (state_d != state_q) && (state_d != LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOCKED;
            duty_q    <= LOCK_V;
            hold_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            is_open_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            busy_q    <= (state_d == OPENING) || (state_d == CLOSING);
            is_open_q <= (state_d == OPEN);
        end
    end

    assign bus.duty      = duty_q;
    assign bus.busy      = busy_q;
    assign bus.is_open   = is_open_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_servo_sweep_sequencer.sv
// Directed bench for the servo sweep sequencer: every change of {duty,busy,is_open,done} must
// match the next queued expectation, including the clock edge on which it happens.
module tb_servo_sweep_sequencer;
    import servo_pkg::*;

    localparam int unsigned RES        = 8;
    localparam int unsigned STEP_TICKS = 3;
    localparam int unsigned DUTY_LOCK  = 10;
    localparam int unsigned DUTY_OPEN  = 14;
    localparam int unsigned HOLD_STEPS = 2;
    localparam int          W          = 28;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    servo_sweep_sequencer_if #(.RES(RES)) bus ();

    servo_sweep_sequencer #(
        .RES        (RES),
        .STEP_TICKS (STEP_TICKS),
        .DUTY_LOCK  (DUTY_LOCK),
        .DUTY_OPEN  (DUTY_OPEN),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset / edge counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 1'b0;
    logic [11:0]  prev_obs;

    function automatic logic [W-1:0] ev(input int c, input int d, input bit b,
                                        input bit o, input bit dn);
        logic [15:0] c16;
        logic [8:0]  d9;
        c16 = 16'(c);
        d9  = 9'(d);
        return {c16, d9, b, o, dn};
    endfunction

    task automatic push(input int c, input int d, input bit b, input bit o, input bit dn);
        exp_q.push_back(ev(c, d, b, o, dn));
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [11:0]  cur;
        logic [W-1:0] act;
        logic [W-1:0] exp;
        cur = {bus.duty, bus.busy, bus.is_open, bus.done};
        if (mon_en && (cur !== prev_obs)) begin
            act = {cyc[15:0], cur};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got cyc=%0d duty=%0d busy=%0d open=%0d done=%0d, none expected",
                         act[27:12], act[11:3], act[2], act[1], act[0]);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d duty=%0d busy=%0d open=%0d done=%0d expected cyc=%0d duty=%0d busy=%0d open=%0d done=%0d",
                             act[27:12], act[11:3], act[2], act[1], act[0],
                             exp[27:12], exp[11:3], exp[2], exp[1], exp[0]);
                end
            end
        end
        prev_obs = cur;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Request is presented during cycle c and sampled on edge c+1.
    task automatic drive(input int c, input bit u, input bit l);
        wait_cyc(c);
        bus.unlock_req = u;
        bus.lock_req   = l;
        @(negedge clk);
        bus.unlock_req = 1'b0;
        bus.lock_req   = 1'b0;
    endtask

    task automatic drain(input string name, input int c);
        wait_cyc(c);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push_open_ramp(input int e0);
        push(e0,      10, 1'b1, 1'b0, 1'b0);
        push(e0 + 4,  11, 1'b1, 1'b0, 1'b0);
        push(e0 + 8,  12, 1'b1, 1'b0, 1'b0);
        push(e0 + 12, 13, 1'b1, 1'b0, 1'b0);
        push(e0 + 16, 14, 1'b0, 1'b1, 1'b1);
        push(e0 + 17, 14, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_close_ramp(input int c);
        push(c,      14, 1'b1, 1'b0, 1'b0);
        push(c + 4,  13, 1'b1, 1'b0, 1'b0);
        push(c + 8,  12, 1'b1, 1'b0, 1'b0);
        push(c + 12, 11, 1'b1, 1'b0, 1'b0);
        push(c + 16, 10, 1'b0, 1'b0, 1'b1);
        push(c + 17, 10, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int e0;
        int e1;
        bus.unlock_req = 1'b0;
        bus.lock_req   = 1'b0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_duty",    int'(bus.duty),      int'(DUTY_LOCK));
        chk("reset_busy",    int'(bus.busy),      0);
        chk("reset_is_open", int'(bus.is_open),   0);
        chk("reset_done",    int'(bus.done),      0);
        chk("reset_state",   int'(bus.state_dbg), int'(LOCKED));
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Full open ramp, hold for HOLD_STEPS ticks, automatic close.
        base = cyc + 2;
        e0   = base + 1;
        push_open_ramp(e0);
        push_close_ramp(e0 + 24);
        drive(base, 1'b1, 1'b0);
        drain("drain_auto_cycle", e0 + 46);

        // lock_req at duty 12 while opening reverses without a duty jump.
        base = cyc + 2;
        e0   = base + 1;
        e1   = e0 + 9;
        push(e0,     10, 1'b1, 1'b0, 1'b0);
        push(e0 + 4, 11, 1'b1, 1'b0, 1'b0);
        push(e0 + 8, 12, 1'b1, 1'b0, 1'b0);
        push(e1 + 4, 11, 1'b1, 1'b0, 1'b0);
        push(e1 + 8, 10, 1'b0, 1'b0, 1'b1);
        push(e1 + 9, 10, 1'b0, 1'b0, 1'b0);
        drive(base, 1'b1, 1'b0);
        drive(e0 + 8, 1'b0, 1'b1);
        drain("drain_reverse", e1 + 14);

        // Both requests together while locked: nothing moves.
        base = cyc + 2;
        drive(base, 1'b1, 1'b1);
        drain("drain_both_locked", base + 10);
        chk("both_locked_state", int'(bus.state_dbg), int'(LOCKED));

        // Both requests together while open: lock wins.
        base = cyc + 2;
        e0   = base + 1;
        push_open_ramp(e0);
        push_close_ramp(e0 + 19);
        drive(base, 1'b1, 1'b0);
        drive(e0 + 18, 1'b1, 1'b1);
        drain("drain_both_open", e0 + 41);

        // Reset mid-close at duty 12 returns straight to the locked stop.
        base = cyc + 2;
        e0   = base + 1;
        push_open_ramp(e0);
        push(e0 + 24, 14, 1'b1, 1'b0, 1'b0);
        push(e0 + 28, 13, 1'b1, 1'b0, 1'b0);
        push(e0 + 32, 12, 1'b1, 1'b0, 1'b0);
        push(e0 + 34, 10, 1'b0, 1'b0, 1'b0);
        drive(base, 1'b1, 1'b0);
        wait_cyc(e0 + 33);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_close_state", int'(bus.state_dbg), int'(LOCKED));
        reset = 1'b0;
        drain("drain_reset_mid_close", e0 + 42);

        // Repeated unlock while opening keeps tick spacing; unlock in OPEN restarts the hold.
        base = cyc + 2;
        e0   = base + 1;
        push_open_ramp(e0);
        push_close_ramp(e0 + 28);
        drive(base, 1'b1, 1'b0);
        drive(e0 + 1, 1'b1, 1'b0);
        drive(e0 + 4, 1'b1, 1'b0);
        drive(e0 + 7, 1'b1, 1'b0);
        drive(e0 + 21, 1'b1, 1'b0);
        drain("drain_repeat_unlock", e0 + 50);
        chk("final_state", int'(bus.state_dbg), int'(LOCKED));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
